// File: rtl/mem_region_map.sv
// Per-channel tag-region lookup with runtime-programmable table; optional table lock via MEM_REGION_MAP_LOCK_EN.
// Latency: 1 cycle, fully pipelined, one lookup per channel per cycle.
// Backpressure: none; responses and fault capture are unconditional.
module mem_region_map #(
    parameter int NUM_CH      = 2,
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32,
    parameter int TAG_W       = 10,
    parameter int FCNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic [NUM_CH-1:0]          resp_cache_en,
    output logic [NUM_CH-1:0]          resp_valid_addr,
    output logic [NUM_CH*4-1:0]        resp_region,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_idx,
`ifdef MEM_REGION_MAP_LOCK_EN
    input  logic [2*TAG_W+2:0]         cfg_wdata,
    output logic                       cfg_locked,
`else
    input  logic [2*TAG_W+1:0]         cfg_wdata,
`endif
    output logic [NUM_CH-1:0]          fault,
    output logic [NUM_CH*ADDR_W-1:0]   fault_addr,
    output logic [NUM_CH*FCNT_W-1:0]   fault_cnt,
    input  logic [NUM_CH-1:0]          fault_clr
);

    logic [NUM_REGIONS-1:0][TAG_W-1:0] base_q;
    logic [NUM_REGIONS-1:0][TAG_W-1:0] mask_q;
    logic [NUM_REGIONS-1:0]            en_q;
    logic [NUM_REGIONS-1:0]            cache_q;

    logic [NUM_CH-1:0][ADDR_W-1:0]     ch_addr;
    logic [NUM_CH-1:0][TAG_W-1:0]      ch_tag;
    logic [NUM_CH-1:0]                 hit;
    logic [NUM_CH-1:0]                 hit_cache;
    logic [NUM_CH-1:0][3:0]            hit_idx;

    logic [NUM_CH-1:0]                 fault_q, fault_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]     fault_addr_q, fault_addr_d;
    logic [NUM_CH-1:0][FCNT_W-1:0]     fault_cnt_q, fault_cnt_d;

    logic                              cfg_wr;
    logic [TAG_W-1:0]                  wr_base;
    logic [TAG_W-1:0]                  wr_mask;
    logic                              wr_cache;
    logic                              wr_en;

    assign wr_base  = cfg_wdata[TAG_W-1:0];
    assign wr_mask  = cfg_wdata[2*TAG_W-1:TAG_W];
    assign wr_cache = cfg_wdata[2*TAG_W];
    assign wr_en    = cfg_wdata[2*TAG_W+1];

`ifdef MEM_REGION_MAP_LOCK_EN
    logic locked_q;

    assign cfg_wr     = cfg_we & ~locked_q;
    assign cfg_locked = locked_q;

    // Lock is set by the same write that carries it, so that write still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (cfg_wr && cfg_wdata[2*TAG_W+2]) begin
            locked_q <= 1'b1;
        end
    end
`else
    assign cfg_wr = cfg_we;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign ch_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
            assign ch_tag[g]  = ch_addr[g][ADDR_W-1 -: TAG_W];
        end
    endgenerate

    // Region table; reset contents reproduce the legacy fixed map (tags 0, 1, 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                base_q[r]  <= (r < 3) ? TAG_W'(r) : '0;
                mask_q[r]  <= (r < 3) ? '1 : '0;
                en_q[r]    <= (r < 3);
                cache_q[r] <= (r == 0) || (r == 2);
            end
        end else begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (cfg_wr && (cfg_idx == 4'(r))) begin
                    base_q[r]  <= wr_base;
                    mask_q[r]  <= wr_mask;
                    en_q[r]    <= wr_en;
                    cache_q[r] <= wr_cache;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit       = '0;
        hit_cache = '0;
        hit_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
                if (en_q[r] && ((ch_tag[c] & mask_q[r]) == (base_q[r] & mask_q[r]))) begin
                    hit[c]       = 1'b1;
                    hit_cache[c] = cache_q[r];
                    hit_idx[c]   = 4'(r);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid      <= '0;
            resp_cache_en   <= '0;
            resp_valid_addr <= '0;
            resp_region     <= '0;
        end else begin
            resp_valid <= req_valid;
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_valid[c]) begin
                    resp_cache_en[c]       <= hit_cache[c];
                    resp_valid_addr[c]     <= hit[c];
                    resp_region[c*4 +: 4]  <= hit_idx[c];
                end
            end
        end
    end

    // Clear is applied before a coincident new fault, so that fault becomes the first one.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_cnt_d  = fault_cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fault_clr[c]) begin
                fault_d[c]      = 1'b0;
                fault_addr_d[c] = '0;
                fault_cnt_d[c]  = '0;
            end
            if (req_valid[c] && !hit[c]) begin
                if (!fault_d[c]) begin
                    fault_addr_d[c] = ch_addr[c];
                end
                fault_d[c] = 1'b1;
                if (fault_cnt_d[c] != '1) begin
                    fault_cnt_d[c] = fault_cnt_d[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= '0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_mem_region_map.sv
// Directed-vector bench for mem_region_map (2 channels, 4 regions, 2-bit fault counter).
module tb_mem_region_map;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 10;
    localparam int FCNT_W = 2;
`ifdef MEM_REGION_MAP_LOCK_EN
    localparam int CFG_W = 2*TAG_W + 3;
`else
    localparam int CFG_W = 2*TAG_W + 2;
`endif

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH*ADDR_W-1:0]  req_addr;
    logic [NUM_CH-1:0]         resp_valid;
    logic [NUM_CH-1:0]         resp_cache_en;
    logic [NUM_CH-1:0]         resp_valid_addr;
    logic [NUM_CH*4-1:0]       resp_region;
    logic                      cfg_we;
    logic [3:0]                cfg_idx;
    logic [CFG_W-1:0]          cfg_wdata;
    logic [NUM_CH-1:0]         fault;
    logic [NUM_CH*ADDR_W-1:0]  fault_addr;
    logic [NUM_CH*FCNT_W-1:0]  fault_cnt;
    logic [NUM_CH-1:0]         fault_clr;
`ifdef MEM_REGION_MAP_LOCK_EN
    logic                      cfg_locked;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_region_map #(
        .NUM_CH(NUM_CH), .NUM_REGIONS(4), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_cache_en(resp_cache_en),
        .resp_valid_addr(resp_valid_addr),
        .resp_region(resp_region),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata),
`ifdef MEM_REGION_MAP_LOCK_EN
        .cfg_locked(cfg_locked),
`endif
        .fault(fault),
        .fault_addr(fault_addr),
        .fault_cnt(fault_cnt),
        .fault_clr(fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        req_valid = v;
        req_addr  = {a1, a0};
    endtask

    task automatic cfg(input logic we, input logic [3:0] idx, input logic lock, input logic en,
                       input logic cache, input logic [9:0] mask, input logic [9:0] base);
        cfg_we  = we;
        cfg_idx = idx;
`ifdef MEM_REGION_MAP_LOCK_EN
        cfg_wdata = {lock, en, cache, mask, base};
`else
        cfg_wdata = {en, cache, mask, base};
        if (lock) cfg_wdata = {en, cache, mask, base};
`endif
    endtask

    initial begin
        rst = 1'b1;
        req(2'b00, 32'h0, 32'h0);
        cfg(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
        fault_clr = '0;
        tick();
        tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_valid_addr", 64'(resp_valid_addr), 64'h0);
        chk("rst_cache_en", 64'(resp_cache_en), 64'h0);
        chk("rst_region", 64'(resp_region), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        chk("rst_fault_addr", 64'(fault_addr), 64'h0);
        chk("rst_fault_cnt", 64'(fault_cnt), 64'h0);
        rst = 1'b0;

        // Legacy map: tag 0 cacheable, tag 1 uncached, tag 2 cacheable
        req(2'b11, 32'h0000_1000, 32'h0040_0000);
        tick();
        chk("def_resp_valid", 64'(resp_valid), 64'h3);
        chk("def_valid_addr", 64'(resp_valid_addr), 64'h3);
        chk("def_cache_en", 64'(resp_cache_en), 64'h1);
        chk("def_region", 64'(resp_region), 64'h10);
        chk("def_fault", 64'(fault), 64'h0);

        // ch1 idle: its attributes hold
        req(2'b01, 32'h0080_0000, 32'h0);
        tick();
        chk("r2_resp_valid", 64'(resp_valid), 64'h1);
        chk("r2_valid_addr", 64'(resp_valid_addr), 64'h3);
        chk("r2_cache_en", 64'(resp_cache_en), 64'h1);
        chk("r2_region", 64'(resp_region), 64'h12);

        // Identical addresses on both channels
        req(2'b11, 32'h0080_0000, 32'h0080_0000);
        tick();
        chk("same_region", 64'(resp_region), 64'h22);
        chk("same_cache_en", 64'(resp_cache_en), 64'h3);
        chk("same_valid_addr", 64'(resp_valid_addr), 64'h3);

        // Miss and first-fault capture on ch1
        req(2'b10, 32'h0, 32'hFFC0_0000);
        tick();
        chk("miss_resp_valid", 64'(resp_valid), 64'h2);
        chk("miss_valid_addr", 64'(resp_valid_addr), 64'h1);
        chk("miss_region", 64'(resp_region), 64'h02);
        chk("miss_fault", 64'(fault), 64'h2);
        chk("miss_fault_addr", 64'(fault_addr), 64'hFFC0_0000_0000_0000);
        chk("miss_fault_cnt", 64'(fault_cnt), 64'h4);

        req(2'b10, 32'h0, 32'h8000_0000);
        tick();
        chk("miss2_fault_addr", 64'(fault_addr), 64'hFFC0_0000_0000_0000);
        chk("miss2_fault_cnt", 64'(fault_cnt), 64'h8);
        tick();
        chk("miss3_fault_cnt", 64'(fault_cnt), 64'hC);
        tick();
        tick();
        chk("miss5_fault_cnt_sat", 64'(fault_cnt), 64'hC);
        chk("miss5_fault", 64'(fault), 64'h2);

        req(2'b00, 32'h0, 32'h0);
        fault_clr = 2'b10;
        tick();
        fault_clr = 2'b00;
        chk("clr_fault", 64'(fault), 64'h0);
        chk("clr_fault_addr", 64'(fault_addr), 64'h0);
        chk("clr_fault_cnt", 64'(fault_cnt), 64'h0);
        chk("clr_resp_valid", 64'(resp_valid), 64'h0);

        // Clear coinciding with a new fault on ch0
        req(2'b01, 32'hFFC0_0000, 32'h0);
        tick();
        chk("f0_fault_addr", 64'(fault_addr), 64'hFFC0_0000);
        req(2'b01, 32'h8000_0000, 32'h0);
        fault_clr = 2'b01;
        tick();
        fault_clr = 2'b00;
        chk("clrf_fault", 64'(fault), 64'h1);
        chk("clrf_fault_addr", 64'(fault_addr), 64'h8000_0000);
        chk("clrf_fault_cnt", 64'(fault_cnt), 64'h1);

        // Out-of-range index must not alias onto a real region
        req(2'b00, 32'h0, 32'h0);
        cfg(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000);
        tick();
        cfg(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
        req(2'b01, 32'h1230_0000, 32'h0);
        tick();
        chk("oor_valid_addr", 64'(resp_valid_addr[0]), 64'h0);

        // Same-edge write uses the old entry
        cfg(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 10'h3F0, 10'h3F0);
        req(2'b01, 32'hFC00_0000, 32'h0);
        tick();
        cfg(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
        chk("wr_same_valid_addr", 64'(resp_valid_addr[0]), 64'h0);
        tick();
        chk("wr_next_valid_addr", 64'(resp_valid_addr[0]), 64'h1);
        chk("wr_next_cache_en", 64'(resp_cache_en[0]), 64'h0);
        chk("wr_next_region", 64'(resp_region[3:0]), 64'h3);

        // Priority: region1 matches everything, region0 still wins for tag 0
        req(2'b00, 32'h0, 32'h0);
        cfg(1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000);
        tick();
        cfg(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
        req(2'b11, 32'h0000_0000, 32'h1230_0000);
        tick();
        chk("pri_region", 64'(resp_region), 64'h10);
        chk("pri_valid_addr", 64'(resp_valid_addr), 64'h3);
        chk("pri_cache_en", 64'(resp_cache_en), 64'h3);

        // Reset mid-operation drops responses and restores the table
        req(2'b11, 32'h0000_1000, 32'h0040_0000);
        tick();
        chk("pre_rst_resp_valid", 64'(resp_valid), 64'h3);
        rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("mid_rst_fault", 64'(fault), 64'h0);
        tick();
        chk("mid_rst_hold", 64'(resp_valid), 64'h0);
        rst = 1'b0;
        req(2'b11, 32'h1230_0000, 32'h0040_0000);
        tick();
        chk("post_rst_region", 64'(resp_region), 64'h10);
        chk("post_rst_valid_addr", 64'(resp_valid_addr), 64'h2);
        chk("post_rst_cache_en", 64'(resp_cache_en), 64'h0);
        chk("post_rst_fault", 64'(fault), 64'h1);

`ifdef MEM_REGION_MAP_LOCK_EN
        req(2'b00, 32'h0, 32'h0);
        cfg(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h000);
        tick();
        chk("lock_set", 64'(cfg_locked), 64'h1);
        cfg(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF);
        tick();
        cfg(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
        req(2'b01, 32'h0000_1000, 32'h0);
        tick();
        chk("lock_valid_addr", 64'(resp_valid_addr[0]), 64'h1);
        chk("lock_cache_en", 64'(resp_cache_en[0]), 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lock_rst", 64'(cfg_locked), 64'h0);
        tick();
        chk("lock_rst_cache_en", 64'(resp_cache_en[0]), 64'h1);
`endif

        req(2'b00, 32'h0, 32'h0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
